wb_interconnect_rr_arb: RTL

- Per-target arbiter for the combinational NxN Wishbone interconnect.
- Sits between one target port and the per-target request vector produced by the address decode.
- Grants exactly one initiator at a time, registered and one-hot. Holds the grant for the whole Wishbone cycle, with round-robin fairness.
- Bounds grant tenure by an ack-count burst limit and an optional no-ack watchdog.

---
 rtl/wb_interconnect_rr_arb.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_interconnect_rr_arb.sv
// ---------------------------------------------------------------------------
// wb_interconnect_rr_arb
//
// Per-target round-robin arbiter for the combinational NxN Wishbone
// interconnect. It takes the per-target request vector produced by the
// address decode and issues a registered one-hot grant. The grant is held for
// the whole Wishbone cycle.
//
// Tenure ends in one of three ways:
//   - the owner drops its request;
//   - the ack-count burst limit is reached while another initiator waits;
//   - the no-ack watchdog expires (optional).
//
// Every release passes through one IDLE cycle. The target therefore never
// sees the address switch in the middle of a cycle.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   Defined   : a no-ack watchdog of TIMEOUT_CYCLES cycles releases the owner
//               and pulses 'timeout' for one cycle.
//   Undefined : no watchdog flops, 'timeout' is tied low, and a target that
//               never acks holds the grant forever.
// ---------------------------------------------------------------------------
module wb_interconnect_rr_arb #(
  parameter int N_REQ          = 2,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  // Burst counter only needs to reach MAX_BURST-1; MAX_BURST==0 disables it.
  localparam int              BC_W           = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] BURST_LAST     = (MAX_BURST > 1) ? BC_W'(MAX_BURST - 1) : {BC_W{1'b0}};
  localparam bit              BURST_LIMIT_EN = (MAX_BURST != 0);
  localparam logic [ID_W-1:0] LAST_ID_RST    = ID_W'(N_REQ - 1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [ID_W-1:0]   gnt_id_r;
  logic              gnt_valid_r;
  logic              timeout_r;
  logic [ID_W-1:0]   last_id_r;
  logic [BC_W-1:0]   burst_cnt_r;
`ifdef WB_ARB_TIMEOUT_EN
  logic [WD_W-1:0]   wd_cnt_r;
`endif

  logic              pick_found_s;
  logic [ID_W-1:0]   pick_id_s;
  logic [N_REQ-1:0]  pick_onehot_s;
  logic              owner_req_s;
  logic              others_req_s;
  logic              burst_rel_s;
  logic              wd_fire_s;
  logic              release_s;

  // Round-robin search: the lowest requester strictly above 'last' wins.
  // Otherwise the lowest requester overall wins (wrap-around).
  // Returns {found, id}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  last);
    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = {ID_W{1'b0}};
    lo_id    = {ID_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        if (ID_W'(i) > last) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
    if (hi_found) begin
      return {1'b1, hi_id};
    end else begin
      return {lo_found, lo_id};
    end
  endfunction

  // Index to one-hot decode.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      oh[i] = (ID_W'(i) == id);
    end
    return oh;
  endfunction

  // Next-winner selection and release decision for the current cycle.
  always_comb begin
    {pick_found_s, pick_id_s} = rr_pick(req, last_id_r);
    pick_onehot_s = id_to_onehot(pick_id_s);
    // gnt_r is one-hot, so this equals req[gnt_id_r] without a variable index.
    owner_req_s   = |(req & gnt_r);
    others_req_s  = |(req & ~gnt_r);
    if (BURST_LIMIT_EN && ack && (burst_cnt_r == BURST_LAST) && others_req_s) begin
      burst_rel_s = 1'b1;
    end else begin
      burst_rel_s = 1'b0;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (!ack && (wd_cnt_r == WD_LAST)) begin
      wd_fire_s = 1'b1;
    end else begin
      wd_fire_s = 1'b0;
    end
`else
    wd_fire_s = 1'b0;
`endif
    release_s = !owner_req_s || wd_fire_s || burst_rel_s;
  end

  // Arbiter FSM with registered grant, counters and timeout pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      gnt_r       <= {N_REQ{1'b0}};
      gnt_id_r    <= {ID_W{1'b0}};
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      last_id_r   <= LAST_ID_RST;
      burst_cnt_r <= {BC_W{1'b0}};
`ifdef WB_ARB_TIMEOUT_EN
      wd_cnt_r    <= {WD_W{1'b0}};
`endif
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r     <= ST_OWN;
            gnt_r       <= pick_onehot_s;
            gnt_id_r    <= pick_id_s;
            gnt_valid_r <= 1'b1;
            last_id_r   <= pick_id_s;
            burst_cnt_r <= {BC_W{1'b0}};
`ifdef WB_ARB_TIMEOUT_EN
            wd_cnt_r    <= {WD_W{1'b0}};
`endif
          end else begin
            gnt_r       <= {N_REQ{1'b0}};
            gnt_id_r    <= {ID_W{1'b0}};
            gnt_valid_r <= 1'b0;
          end
        end
        ST_OWN: begin
          if (release_s) begin
            // The owner keeps its round-robin slot, so the next requester wins.
            state_r     <= ST_IDLE;
            gnt_r       <= {N_REQ{1'b0}};
            gnt_id_r    <= {ID_W{1'b0}};
            gnt_valid_r <= 1'b0;
            // Request drop has priority: a watchdog hit in that cycle is silent.
            timeout_r   <= owner_req_s && wd_fire_s;
          end else if (ack) begin
            if (burst_cnt_r != BURST_LAST) begin
              burst_cnt_r <= burst_cnt_r + 1'b1;
            end else begin
              burst_cnt_r <= burst_cnt_r;
            end
`ifdef WB_ARB_TIMEOUT_EN
            wd_cnt_r    <= {WD_W{1'b0}};
`endif
          end else begin
`ifdef WB_ARB_TIMEOUT_EN
            wd_cnt_r    <= wd_cnt_r + 1'b1;
`endif
            burst_cnt_r <= burst_cnt_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= {N_REQ{1'b0}};
          gnt_id_r    <= {ID_W{1'b0}};
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule
